// File: rtl/ptp_pkg.sv
`default_nettype none
//==============================================================================
// Package : ptp_pkg
// Shared states, byte constants and header helper for the fake-PTP generator.
// Rev     : 1.0
//==============================================================================
package ptp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_HDR,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } ptp_state_t;

   localparam logic [7:0] PREAMBLE_B = 8'h55;
   localparam logic [7:0] SFD_B      = 8'hD5;

   localparam logic [7:0] FAKE_DMAC_0 = 8'h00;
   localparam logic [7:0] FAKE_DMAC_1 = 8'h01;
   localparam logic [7:0] FAKE_DMAC_2 = 8'h02;
   localparam logic [7:0] FAKE_DMAC_3 = 8'h03;
   localparam logic [7:0] FAKE_DMAC_4 = 8'h04;
   localparam logic [7:0] FAKE_DMAC_5 = 8'h05;

   localparam logic [1:0] PTP_TYPE_HOST        = 2'd0;
   localparam logic [1:0] PTP_TYPE_MASTER_SYNC = 2'd1;
   localparam logic [1:0] PTP_TYPE_SLAVE_RESP  = 2'd2;
   localparam logic [1:0] PTP_TYPE_MASTER_FIN  = 2'd3;

   localparam int HDR_LEN = 16;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

   // Byte bc of the 16-byte fake-PTP header; ts already carries the send slot.
   function automatic logic [7:0] hdr_byte(input logic [5:0]  bc,
                                           input logic [1:0]  ptp_type,
                                           input logic [63:0] ts);
      logic [7:0] b;
      b = 8'h00;
      if (bc[5:3] == 3'b001) begin
         case (bc[2:0])
            3'd0:    b = ts[63:56];
            3'd1:    b = ts[55:48];
            3'd2:    b = ts[47:40];
            3'd3:    b = ts[39:32];
            3'd4:    b = ts[31:24];
            3'd5:    b = ts[23:16];
            3'd6:    b = ts[15:8];
            default: b = ts[7:0];
         endcase
      end else begin
         case (bc)
            6'd0:    b = FAKE_DMAC_0;
            6'd1:    b = FAKE_DMAC_1;
            6'd2:    b = FAKE_DMAC_2;
            6'd3:    b = FAKE_DMAC_3;
            6'd4:    b = FAKE_DMAC_4;
            6'd5:    b = FAKE_DMAC_5;
            6'd6:    b = {6'b0, ptp_type};
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

endpackage : ptp_pkg
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
//==============================================================================
// Module : crc32_d8
// Ethernet CRC32 (reflected), one byte per cycle; raw register, no final xor.
// Rev    : 1.0
//==============================================================================
module crc32_d8
   import ptp_pkg::*;
(
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] r_crc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC32_POLY : 32'h0);
      end
      return r;
   endfunction

   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= '1;
      end else if (clr) begin
         r_crc <= '1;
      end else if (en) begin
         r_crc <= crc_byte(r_crc, data);
      end
   end

   assign crc = r_crc;

endmodule : crc32_d8
`default_nettype wire

// File: rtl/ptp_fake_pkt_gen.sv
`default_nettype none
//==============================================================================
// Module : ptp_fake_pkt_gen
// Fake-PTP frame generator on GMII TX; FCS appended when PTP_GEN_FCS_EN is set.
// Rev    : 1.0
//==============================================================================
module ptp_fake_pkt_gen
   import ptp_pkg::*;
#(
   parameter int IFG_CYCLES  = 12,
   parameter int MIN_FRAME_B = 60
) (
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  start_type,
   input  logic [63:0] start_ts,
   input  logic [15:0] local_time,
   output logic        ready,
   output logic        done,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic [31:0] cnt_sent
);

   localparam logic [7:0] C_PRE_LAST = 8'd6;
   localparam logic [5:0] C_HDR_LAST = 6'(HDR_LEN - 1);
   localparam logic [5:0] C_PAD_LAST = 6'(MIN_FRAME_B - 1);
   // The IDLE cycle before the next start is part of the gap, so IFG holds one less.
   localparam logic [7:0] C_IFG_LAST = 8'(IFG_CYCLES - 2);

   ptp_state_t  r_state, w_state_nxt;
   logic [5:0]  r_bc, w_bc_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [1:0]  r_type;
   logic [63:0] r_ts, w_ts_eff;
   logic [15:0] r_send_ts;
   logic [7:0]  r_txd, w_txd_nxt;
   logic        r_tx_en, w_tx_en_nxt;
   logic        r_tx_er;
   logic        r_done, w_done_nxt;
   logic [31:0] r_cnt_sent;

   always_comb begin
      w_state_nxt = r_state;
      w_bc_nxt    = r_bc;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_PREAMBLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_PREAMBLE: begin
            if (r_cnt == C_PRE_LAST) w_state_nxt = ST_SFD;
            else                     w_cnt_nxt   = r_cnt + 8'd1;
         end
         ST_SFD: begin
            w_state_nxt = ST_HDR;
            w_bc_nxt    = '0;
         end
         ST_HDR: begin
            w_bc_nxt = r_bc + 6'd1;
            if (r_bc == C_HDR_LAST) w_state_nxt = ST_PAD;
         end
         ST_PAD: begin
            w_bc_nxt  = r_bc + 6'd1;
            w_cnt_nxt = '0;
`ifdef PTP_GEN_FCS_EN
            if (r_bc == C_PAD_LAST) w_state_nxt = ST_FCS;
`else
            if (r_bc == C_PAD_LAST) w_state_nxt = ST_IFG;
`endif
         end
`ifdef PTP_GEN_FCS_EN
         ST_FCS: begin
            if (r_cnt == 8'd3) begin
               w_state_nxt = ST_IFG;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
`endif
         ST_IFG: begin
            if (r_cnt == C_IFG_LAST) w_state_nxt = ST_IDLE;
            else                     w_cnt_nxt   = r_cnt + 8'd1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ts_eff = r_ts;
      case (r_type)
         PTP_TYPE_HOST, PTP_TYPE_MASTER_SYNC: w_ts_eff[63:48] = r_send_ts;
         PTP_TYPE_SLAVE_RESP:                 w_ts_eff[31:16] = r_send_ts;
         PTP_TYPE_MASTER_FIN:                 w_ts_eff        = r_ts;
         default:                             w_ts_eff        = r_ts;
      endcase
   end

`ifdef PTP_GEN_FCS_EN
   logic [31:0] w_crc;
   logic [7:0]  w_fcs_byte;
   logic        w_crc_clr, w_crc_en;

   assign w_crc_clr = (w_state_nxt == ST_SFD);
   assign w_crc_en  = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_PAD);

   crc32_d8 u_crc32_d8 (
      .gmii_rx_clk (gmii_rx_clk),
      .rst_n       (rst_n),
      .clr         (w_crc_clr),
      .en          (w_crc_en),
      .data        (w_txd_nxt),
      .crc         (w_crc)
   );

   always_comb begin
      case (w_cnt_nxt[1:0])
         2'd0:    w_fcs_byte = ~w_crc[7:0];
         2'd1:    w_fcs_byte = ~w_crc[15:8];
         2'd2:    w_fcs_byte = ~w_crc[23:16];
         default: w_fcs_byte = ~w_crc[31:24];
      endcase
   end
`endif

   // Outputs are decoded from the next state so they register on the same edge.
   always_comb begin
      w_tx_en_nxt = 1'b1;
      w_txd_nxt   = 8'h00;
      case (w_state_nxt)
         ST_PREAMBLE: w_txd_nxt = PREAMBLE_B;
         ST_SFD:      w_txd_nxt = SFD_B;
         ST_HDR:      w_txd_nxt = hdr_byte(w_bc_nxt, r_type, w_ts_eff);
         ST_PAD:      w_txd_nxt = 8'h00;
`ifdef PTP_GEN_FCS_EN
         ST_FCS:      w_txd_nxt = w_fcs_byte;
`endif
         default:     w_tx_en_nxt = 1'b0;
      endcase
      w_done_nxt = (w_state_nxt == ST_IFG) && (r_state != ST_IFG);
   end

   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_bc       <= '0;
         r_cnt      <= '0;
         r_type     <= '0;
         r_ts       <= '0;
         r_send_ts  <= '0;
         r_txd      <= '0;
         r_tx_en    <= 1'b0;
         r_tx_er    <= 1'b0;
         r_done     <= 1'b0;
         r_cnt_sent <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_bc    <= w_bc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_txd   <= w_txd_nxt;
         r_tx_en <= w_tx_en_nxt;
         r_tx_er <= 1'b0;
         r_done  <= w_done_nxt;
         if (r_state == ST_IDLE && start) begin
            r_type <= start_type;
            r_ts   <= start_ts;
         end
         if (r_state == ST_PREAMBLE && w_state_nxt == ST_SFD) r_send_ts <= local_time;
         if (w_done_nxt) r_cnt_sent <= r_cnt_sent + 32'd1;
      end
   end

   assign ready      = (r_state == ST_IDLE);
   assign done       = r_done;
   assign gmii_txd   = r_txd;
   assign gmii_tx_en = r_tx_en;
   assign gmii_tx_er = r_tx_er;
   assign cnt_sent   = r_cnt_sent;

endmodule : ptp_fake_pkt_gen
`default_nettype wire

// File: tb/tb_ptp_fake_pkt_gen.sv
`default_nettype none
//==============================================================================
// Module : tb_ptp_fake_pkt_gen
// Scoreboard bench for ptp_fake_pkt_gen; follows PTP_GEN_FCS_EN like the DUT.
// Rev    : 1.0
//==============================================================================
module tb_ptp_fake_pkt_gen;

   localparam int IFG_CYCLES  = 12;
   localparam int MIN_FRAME_B = 60;
`ifdef PTP_GEN_FCS_EN
   localparam int FCS_B = 4;
`else
   localparam int FCS_B = 0;
`endif
   localparam int FRAME_LEN = 8 + MIN_FRAME_B + FCS_B;
   localparam int PERIOD    = FRAME_LEN + IFG_CYCLES;

   logic        gmii_rx_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  start_type = '0;
   logic [63:0] start_ts = '0;
   logic [15:0] local_time = '0;
   logic        ready, done, gmii_tx_en, gmii_tx_er;
   logic [7:0]  gmii_txd;
   logic [31:0] cnt_sent;

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   ptp_fake_pkt_gen #(
      .IFG_CYCLES  (IFG_CYCLES),
      .MIN_FRAME_B (MIN_FRAME_B)
   ) dut (
      .gmii_rx_clk (gmii_rx_clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_type  (start_type),
      .start_ts    (start_ts),
      .local_time  (local_time),
      .ready       (ready),
      .done        (done),
      .gmii_txd    (gmii_txd),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_tx_er  (gmii_tx_er),
      .cnt_sent    (cnt_sent)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_frames = 0;
   int         exp_cnt = 0;
   bit         b2b_mode = 1'b0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if ((r[0] ^ d[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
         else                       r = r >> 1;
      end
      return r;
   endfunction

   function automatic void push_frame(input logic [1:0] typ, input logic [63:0] ts,
                                      input logic [15:0] lt);
      logic [63:0] t;
      logic [7:0]  v;
`ifdef PTP_GEN_FCS_EN
      logic [31:0] c;
      c = 32'hFFFFFFFF;
`endif
      t = ts;
      if (typ == 2'd0 || typ == 2'd1) t[63:48] = lt;
      else if (typ == 2'd2)           t[31:16] = lt;
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < MIN_FRAME_B; i++) begin
         if (i < 6)                v = 8'(i);
         else if (i == 6)          v = {6'b0, typ};
         else if (i >= 8 && i < 16) v = t[63 - 8*(i-8) -: 8];
         else                      v = 8'h00;
         exp_q.push_back(v);
`ifdef PTP_GEN_FCS_EN
         c = crc_upd(c, v);
`endif
      end
`ifdef PTP_GEN_FCS_EN
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
`endif
   endfunction

   // Output monitor: scoreboard pop, frame length, gap, done and counter tracking.
   int         run_len = 0;
   int         gap_len = 0;
   bit         b2b_started = 1'b0;
   logic       prev_en = 1'b0;
   logic [7:0] obs[$];

   always @(negedge gmii_rx_clk) begin
      if (!rst_n) begin
         run_len = 0;
         gap_len = 0;
         prev_en = 1'b0;
         obs.delete();
      end else begin
         if (done && !(prev_en && !gmii_tx_en)) check("done_spurious", done, 0);
         if (gmii_tx_en) begin
            if (!prev_en) begin
               if (b2b_mode && b2b_started) check("ifg_len", gap_len, IFG_CYCLES);
               if (b2b_mode) b2b_started = 1'b1;
            end
            if (exp_q.size() == 0) check("txd_unexpected", 64'(exp_q.size()), 1);
            else                   check("txd", gmii_txd, exp_q.pop_front());
            run_len++;
            if (run_len > 8) obs.push_back(gmii_txd);
            gap_len = 0;
         end else begin
            if (prev_en) begin
               check("tx_en_len", run_len, FRAME_LEN);
               check("done_at_end", done, 1);
               check("tx_er", gmii_tx_er, 0);
`ifdef PTP_GEN_FCS_EN
               begin
                  logic [31:0] c, r;
                  c = 32'hFFFFFFFF;
                  foreach (obs[k]) c = crc_upd(c, obs[k]);
                  for (int b = 0; b < 32; b++) r[b] = c[31-b];
                  check("fcs_residue", r, 32'hC704DD7B);
               end
`endif
               run_len = 0;
               obs.delete();
            end
            gap_len++;
         end
         if (done) begin
            exp_cnt++;
            check("cnt_sent", cnt_sent, exp_cnt);
         end
         prev_en = gmii_tx_en;
      end
   end

   task automatic wait_ready();
      int k;
      k = 0;
      while (!ready && k < 500) begin
         @(negedge gmii_rx_clk);
         k++;
      end
      if (!ready) check("ready_wait", ready, 1);
   endtask

   task automatic start_frame(input logic [1:0] typ, input logic [63:0] ts, input logic [15:0] lt);
      wait_ready();
      start_type = typ;
      start_ts   = ts;
      local_time = lt;
      start      = 1'b1;
      push_frame(typ, ts, lt);
      @(negedge gmii_rx_clk);
      start = 1'b0;
      check("ready_drop", ready, 0);
      check("first_en", gmii_tx_en, 1);
   endtask

   task automatic finish_frame(input logic [15:0] lt);
      int t_done, t_ready;
      t_done  = 0;
      t_ready = 0;
      for (int i = 2; i <= 400 && t_ready == 0; i++) begin
         @(negedge gmii_rx_clk);
         if (i == 9) local_time = ~lt;
         if (done && t_done == 0) t_done = i;
         if (ready) t_ready = i;
      end
      n_frames++;
      check("lat_done", t_done, FRAME_LEN + 1);
      check("lat_ready", t_ready, FRAME_LEN + IFG_CYCLES);
      check("q_drained", exp_q.size(), 0);
      check("cnt_total", cnt_sent, n_frames);
   endtask

   task automatic send(input logic [1:0] typ, input logic [63:0] ts, input logic [15:0] lt);
      start_frame(typ, ts, lt);
      finish_frame(lt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dn, k;
      repeat (3) @(negedge gmii_rx_clk);
      check("rst_txd", gmii_txd, 0);
      check("rst_tx_en", gmii_tx_en, 0);
      check("rst_tx_er", gmii_tx_er, 0);
      check("rst_done", done, 0);
      check("rst_cnt", cnt_sent, 0);
      check("rst_ready", ready, 1);
      #1 rst_n = 1'b1;

      // Reset at frame byte 20: truncated frame, no done, counter untouched.
      start_frame(2'd0, 64'h0, 16'h1234);
      repeat (28) @(negedge gmii_rx_clk);
      check("byte20_en", gmii_tx_en, 1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_tx_en", gmii_tx_en, 0);
      check("midrst_ready", ready, 1);
      check("midrst_done", done, 0);
      @(negedge gmii_rx_clk);
      #1 rst_n = 1'b1;
      dn = 0;
      repeat (120) begin
         @(negedge gmii_rx_clk);
         if (done) dn++;
      end
      check("midrst_no_done", dn, 0);
      check("midrst_cnt", cnt_sent, 0);
      check("midrst_idle_en", gmii_tx_en, 0);

      send(2'd0, 64'h0, 16'h1234);
      send(2'd2, 64'h1111_2222_3333_4444, 16'hABCD);
      send(2'd3, 64'h0102_0304_0506_0708, 16'hBEEF);
      send(2'd1, {32'($urandom), 32'($urandom)}, 16'($urandom));

      // Start held high for 200 cycles: accepts only at ready, one frame per period.
      wait_ready();
      n = 0;
      for (int j = 0; 1 + j*PERIOD <= 200; j++) n++;
      for (int j = 0; j < n; j++) push_frame(2'd1, 64'hA5A5_5A5A_0F0F_F0F0, 16'h4321);
      b2b_mode   = 1'b1;
      start_type = 2'd1;
      start_ts   = 64'hA5A5_5A5A_0F0F_F0F0;
      local_time = 16'h4321;
      start      = 1'b1;
      repeat (200) @(negedge gmii_rx_clk);
      start = 1'b0;
      k = 0;
      while (!ready && k < 400) begin
         @(negedge gmii_rx_clk);
         k++;
      end
      n_frames += n;
      check("b2b_ready", ready, 1);
      check("b2b_q", exp_q.size(), 0);
      check("b2b_cnt", cnt_sent, n_frames);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ptp_fake_pkt_gen
`default_nettype wire
